// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: op codes, flag layout, FSM states.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_NAND = 3'd2,
        OP_NOP  = 3'd3,
        OP_MUL  = 3'd4,
        OP_SHL  = 3'd5,
        OP_SHR  = 3'd6,
        OP_RSV  = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int FN = 3;
    localparam int FZ = 2;
    localparam int FC = 1;
    localparam int FV = 0;

    function automatic logic [3:0] mk_flags(
        input logic n,
        input logic z,
        input logic c,
        input logic v
    );
        logic [3:0] f;
        f     = '0;
        f[FN] = n;
        f[FZ] = z;
        f[FC] = c;
        f[FV] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle datapath: ADD, SUB, NAND and their flags.
import alu_pkg::*;

module alu_core #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              op,
    output logic [WIDTH-1:0] res,
    output logic [3:0]       flags
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0] sum;
    logic           c;
    logic           v;

    always_comb begin
        sum = '0;
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (op)
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                res = sum[MSB:0];
                c   = sum[WIDTH];
                v   = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
            end
            OP_SUB: begin
                sum = {1'b0, a} + {1'b0, ~b} + 1'b1;
                res = sum[MSB:0];
                c   = sum[WIDTH];
                v   = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
            end
            OP_NAND: res = ~(a & b);
            default: ;
        endcase
        flags = mk_flags(res[MSB], res == '0, c, v);
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops via alu_core, iterative MUL and
// bit-serial shifts, valid/ready handshake on both sides.
import alu_pkg::*;

module alu_mc #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;

    state_t             state;
    state_t             state_n;
    op_t                op_i;
    op_t                op_q;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      k;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nx;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   sh;
    logic [WIDTH-1:0]   sh_nx;
    logic [WIDTH-1:0]   fin_res;
    logic [WIDTH-1:0]   core_res;
    logic [3:0]         core_flags;
    logic               sh_co;
    logic               fin_c;
    logic               accept;
    logic               last;

    assign op_i   = op_t'(op);
    assign k      = {1'b0, b[SW-1:0]};
    assign accept = in_valid && in_ready;
    assign last   = (cnt == CW'(1));

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a     (a),
        .b     (b),
        .op    (op_i),
        .res   (core_res),
        .flags (core_flags)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (op_i == OP_MUL)
                        state_n = BUSY;
                    else if ((op_i == OP_SHL || op_i == OP_SHR) && k != '0)
                        state_n = BUSY;
                    else
                        state_n = DONE;
                end
            end
            BUSY: if (last) state_n = DONE;
            DONE: if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // acc doubles as the product accumulator and the shift register
    always_comb begin
        in_ready = (state == IDLE) && !rst;
        sh       = acc[WIDTH-1:0];
        acc_nx   = acc + (mplier[0] ? mcand : '0);
        if (op_q == OP_SHL) begin
            sh_nx = sh << 1;
            sh_co = sh[WIDTH-1];
        end else begin
            sh_nx = sh >> 1;
            sh_co = sh[0];
        end
        if (op_q == OP_MUL) begin
            fin_res = acc_nx[WIDTH-1:0];
            fin_c   = |acc_nx[2*WIDTH-1:WIDTH];
        end else begin
            fin_res = sh_nx;
            fin_c   = sh_co;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            op_q      <= OP_NOP;
        end else begin
            out_valid <= (state_n == DONE);
            if (accept) begin
                op_q <= op_i;
                case (op_i)
                    OP_ADD, OP_SUB, OP_NAND: begin
                        result <= core_res;
                        flags  <= core_flags;
                    end
                    OP_MUL: begin
                        acc    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, a};
                        mplier <= b;
                        cnt    <= CW'(WIDTH);
                    end
                    OP_SHL, OP_SHR: begin
                        acc <= {{WIDTH{1'b0}}, a};
                        cnt <= k;
                        if (k == '0) begin
                            result <= a;
                            flags  <= mk_flags(a[WIDTH-1], a == '0, 1'b0, 1'b0);
                        end
                    end
                    default: ;
                endcase
            end else if (state == BUSY) begin
                cnt <= cnt - 1'b1;
                if (op_q == OP_MUL) begin
                    acc    <= acc_nx;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                end else begin
                    acc[WIDTH-1:0] <= sh_nx;
                end
                if (last) begin
                    result <= fin_res;
                    flags  <= mk_flags(fin_res[WIDTH-1], fin_res == '0, fin_c, 1'b0);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: directed corner cases plus random ops
// against an arithmetic reference model.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [2:0]  op = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] result;
    logic [3:0]  flags;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] r;
        logic [3:0]  f;
        int          t;
    } exp_t;

    exp_t sb[$];
    logic [15:0] last_r = '0;
    logic [3:0]  last_f = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_mc #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
        exp_t e;
        int sx, sy, s, k;
        logic [31:0] p;
        logic [15:0] r;
        logic c, v;
        sx = $signed(x);
        sy = $signed(y);
        k = int'(y[3:0]);
        c = 1'b0;
        v = 1'b0;
        r = last_r;
        e.t = 1;
        case (o)
            3'd0: begin
                s = sx + sy;
                r = x + y;
                c = (int'(x) + int'(y)) > 65535;
                v = (s > 32767) || (s < -32768);
            end
            3'd1: begin
                s = sx - sy;
                r = x - y;
                c = (x >= y);
                v = (s > 32767) || (s < -32768);
            end
            3'd2: r = ~(x & y);
            3'd4: begin
                p = 32'(x) * 32'(y);
                r = p[15:0];
                c = (p[31:16] != 0);
                e.t = 17;
            end
            3'd5: begin
                p = 32'(x) << k;
                r = p[15:0];
                if (k > 0) c = p[16];
                e.t = k + 1;
            end
            3'd6: begin
                r = x >> k;
                if (k > 0) c = x[k-1];
                e.t = k + 1;
            end
            default: ;
        endcase
        if (o == 3'd3 || o == 3'd7) begin
            e.r = last_r;
            e.f = last_f;
        end else begin
            e.r = r;
            e.f = {r[15], r == 16'h0, c, v};
        end
        last_r = e.r;
        last_f = e.f;
        return e;
    endfunction

    initial begin
        logic pv;
        exp_t e;
        pv = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid && !pv) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: got result %h with no request pending", result);
                end else begin
                    e = sb.pop_front();
                    chk("result", 32'(result), 32'(e.r));
                    chk("flags", 32'(flags), 32'(e.f));
                    chk("latency", cyc, e.t);
                end
            end
            pv = out_valid;
        end
    end

    task automatic run(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y, input int hold);
        exp_t e;
        int n;
        logic [15:0] hr;
        logic [3:0] hf;
        chk("in_ready_idle", 32'(in_ready), 1);
        e = model(o, x, y);
        e.t = e.t + cyc;
        sb.push_back(e);
        out_ready = (hold == 0);
        in_valid = 1'b1;
        a = x;
        b = y;
        op = o;
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        op = 3'($urandom);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            total++;
            bad++;
            $display("FAIL timeout: op %0d gave no out_valid in 40 cycles", o);
        end
        if (hold > 0) begin
            hr = result;
            hf = flags;
            for (int i = 0; i < hold; i++) begin
                in_valid = 1'b1;
                op = 3'($urandom);
                a = 16'($urandom);
                b = 16'($urandom);
                @(negedge clk);
                chk("hold_valid", 32'(out_valid), 1);
                chk("hold_result", 32'(result), 32'(hr));
                chk("hold_flags", 32'(flags), 32'(hf));
                chk("hold_in_ready", 32'(in_ready), 0);
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits;
        logic [2:0] ro;
        #12;
        chk("rst_result", 32'(result), 0);
        chk("rst_flags", 32'(flags), 0);
        chk("rst_valid", 32'(out_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        run(3'd0, 16'h7FFF, 16'h0001, 0);
        run(3'd1, 16'h0005, 16'h0005, 0);
        run(3'd1, 16'h0000, 16'h0001, 0);
        run(3'd4, 16'h0100, 16'h0100, 0);
        run(3'd4, 16'h0003, 16'h0005, 0);
        run(3'd5, 16'h8001, 16'h0001, 0);
        run(3'd6, 16'h00F0, 16'h0000, 0);
        run(3'd6, 16'h8421, 16'h000F, 0);
        run(3'd0, 16'h1234, 16'h1111, 5);
        run(3'd3, 16'hDEAD, 16'hBEEF, 0);
        run(3'd2, 16'hF0F0, 16'hFF00, 0);
        run(3'd7, 16'h0000, 16'h0000, 0);
        for (int i = 0; i < 50; i++) begin
            ro = 3'($urandom_range(0, 7));
            run(ro, 16'($urandom), 16'($urandom),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end
        run(3'd0, 16'h0001, 16'h0001, 0);
        chk("in_ready_pre_abort", 32'(in_ready), 1);
        in_valid = 1'b1;
        op = 3'd4;
        a = 16'h1234;
        b = 16'h5678;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_result", 32'(result), 0);
        chk("abort_flags", 32'(flags), 0);
        chk("abort_valid", 32'(out_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        last_r = '0;
        last_f = '0;
        #1;
        chk("abort_in_ready", 32'(in_ready), 1);
        hits = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) hits++;
        end
        chk("abort_no_valid", hits, 0);
        run(3'd3, 16'h1111, 16'h2222, 0);
        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width; power of two, >= 4.
REQ-002 Derived constant SW = log2(WIDTH): width of the shift-amount field.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operation request present.
REQ-006 in_ready  output  1  block can accept a request; high only in IDLE.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 op  input  3  operation code.
REQ-010 out_valid  output  1  result and flags are valid.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 result  output  WIDTH  operation result.
REQ-013 flags  output  4  {N, Z, C, V}.

Function
REQ-014 op encoding SHALL be: 000 ADD; 001 SUB (a + ~b + 1); 010 NAND; 011 NOP; 100 MUL (low WIDTH bits); 101 SHL by b[SW-1:0]; 110 SHR (logical) by b[SW-1:0]; 111 reserved, executed as NOP.
REQ-015 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-016 A request SHALL be accepted on any cycle with in_valid && in_ready; a, b and op are latched at that edge and ignored until the next acceptance.
REQ-017 ADD, SUB, NAND, NOP and the reserved code SHALL go IDLE->DONE, with out_valid high one cycle after acceptance.
REQ-018 MUL SHALL use iterative shift-add with a 2*WIDTH accumulator, one multiplier bit per cycle.
REQ-019 MUL SHALL spend exactly WIDTH cycles in BUSY; out_valid is high WIDTH+1 cycles after acceptance.
REQ-020 SHL/SHR SHALL shift one bit per cycle: shift amount k gives k cycles in BUSY and latency k+1.
REQ-021 A shift with k = 0 SHALL go directly to DONE, result = a, latency 1.
REQ-022 In DONE: out_valid = 1, result and flags stable, in_ready = 0.
REQ-023 DONE SHALL transition to IDLE on the cycle out_ready = 1; it SHALL hold indefinitely while out_ready = 0.
REQ-024 Throughput for single-cycle ops SHALL be one result per two cycles (no overlap of DONE and acceptance).
REQ-025 in_valid while in_ready = 0 SHALL have no effect; that request is not queued.
REQ-026 Z SHALL be 1 iff result == 0.
REQ-027 N SHALL equal result[WIDTH-1].
REQ-028 C SHALL be: ADD carry-out; SUB carry-out of a + ~b + 1 (1 when a >= b unsigned); SHL/SHR last bit shifted out, 0 for k = 0; MUL 1 iff the upper WIDTH product bits are nonzero; NAND 0.
REQ-029 V SHALL be signed overflow for ADD/SUB and 0 for all other ops.
REQ-030 NOP and the reserved code SHALL leave result and flags unchanged from the previous operation, but still produce an out_valid handshake.
REQ-031 All arithmetic SHALL wrap modulo 2^WIDTH.
REQ-032 out_valid, result and flags SHALL be registered outputs.

Reset
REQ-033 Asserting rst SHALL immediately force: state IDLE; result, flags and out_valid to 0; in_ready to 1 once rst is released.
REQ-034 rst during BUSY or DONE SHALL abort the operation; no out_valid is produced for it.
REQ-035 The first edge after rst deasserts SHALL be able to accept a request.

Structure
REQ-036 Shared package alu_pkg SHALL hold: op-code constants/enum, flag bit indices (N=3, Z=2, C=1, V=0) and the FSM state enum.
REQ-037 A combinational sub-module alu_core SHALL compute the single-cycle ops (ADD/SUB/NAND) and their flags.
REQ-038 alu_mc SHALL own the FSM, the MUL/shift iteration counter, the accumulator and the handshake.

Verification (WIDTH = 16)
REQ-039 ADD 0x7FFF + 0x0001 -> result 0x8000, N=1 Z=0 C=0 V=1, out_valid 1 cycle after accept.
REQ-040 SUB 0x0005 - 0x0005 -> 0x0000, Z=1 C=1 V=0; SUB 0x0000 - 0x0001 -> 0xFFFF, N=1 C=0.
REQ-041 MUL 0x0100 * 0x0100 -> 0x0000, Z=1 C=1, out_valid exactly 17 cycles after accept; MUL 0x0003 * 0x0005 -> 0x000F, C=0.
REQ-042 SHL 0x8001 by 1 -> 0x0002, C=1, latency 2; SHR 0x00F0 by 0 -> 0x00F0, C=0, latency 1.
REQ-043 out_ready held low 5 cycles in DONE -> out_valid, result and flags held, in_ready = 0, concurrent in_valid ignored; a following NOP returns the held result and flags.
REQ-044 rst asserted mid-MUL (cycle 8) -> result, flags and out_valid = 0 immediately, in_ready = 1 after release, no out_valid for the aborted op.
